// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: TLB maintenance op sequencer (SRCH/RD/WR/FILL/INV)
// Sits between EXE and addr_trans; produces CSR writebacks.
//
// Optional feature macro: INVTLB_OP_CHECK_EN
//   defined   : INVTLB with op > 6 raises op_ine, no invalidate
//   undefined : every op is passed on, op_ine is always 0
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   op_valid/op_ready      op handshake from EXE (ready only in IDLE)
//   op_type, inv_*         op kind and INVTLB operands
//   flush                  pipeline flush from WB
//   csr_tlbehi/tlbidx      search key and RD index / writeback base
//   tlbwr_en, tlbfill_en   addr_trans write strobes, rand_index
//   invtlb_*               addr_trans invalidate port
//   srch_*                 addr_trans data-port search
//   rd_*                   addr_trans read port
//   tlbidx_we/wdata        TLBIDX writeback
//   tlbrd_we, *_wdata      TLBEHI/ELO0/ELO1/ASID writeback
//   op_done, refetch       completion and refetch pulses
//   op_ine                 INE exception pulse
module tlb_op_ctrl #(
  parameter int TLBNUM = 32,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_type,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vpn,
  input  logic             flush,
  input  logic [31:0]      csr_tlbehi,
  input  logic [31:0]      csr_tlbidx,
  output logic             tlbwr_en,
  output logic             tlbfill_en,
  output logic [IDX_W-1:0] rand_index,
  output logic             invtlb_en,
  output logic [4:0]       invtlb_op,
  output logic [9:0]       invtlb_asid,
  output logic [18:0]      invtlb_vpn,
  output logic             srch_fetch,
  output logic [31:0]      srch_vaddr,
  input  logic             srch_found,
  input  logic [IDX_W-1:0] srch_index,
  output logic [IDX_W-1:0] rd_index,
  input  logic [31:0]      rd_tlbehi,
  input  logic [31:0]      rd_tlbelo0,
  input  logic [31:0]      rd_tlbelo1,
  input  logic [31:0]      rd_tlbidx,
  input  logic [9:0]       rd_asid,
  output logic             tlbidx_we,
  output logic [31:0]      tlbidx_wdata,
  output logic             tlbrd_we,
  output logic [31:0]      ehi_wdata,
  output logic [31:0]      elo0_wdata,
  output logic [31:0]      elo1_wdata,
  output logic [9:0]       asid_wdata,
  output logic             op_done,
  output logic             refetch,
  output logic             op_ine
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDX_W-1:0] CNT_MAX =
    IDX_W'(TLBNUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic             ine_q, ine_d;
  logic             kill_q, kill_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic [4:0]       iop_q, iop_d;
  logic [9:0]       iasid_q, iasid_d;
  logic [18:0]      ivpn_q, ivpn_d;
  logic [31:0]      vaddr_q, vaddr_d;
  logic [IDX_W-1:0] rdidx_q, rdidx_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      idxw_q, idxw_d;
  logic [31:0]      ehi_q, ehi_d;
  logic [31:0]      elo0_q, elo0_d;
  logic [31:0]      elo1_q, elo1_d;
  logic [9:0]       asid_q, asid_d;

  logic accept;
  logic known;
  logic inv_bad;
  logic st_issue;
  logic st_resp;
  logic st_done;
  logic done_ok;
  logic ref_typ;
  logic unused_bits;

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] x
  );
    if (x == CNT_MAX) return '0;
    return x + 1'b1;
  endfunction

  assign unused_bits = ^{csr_tlbehi[12:0],
                         rd_tlbidx[30],
                         rd_tlbidx[23:0]};

  assign accept = op_valid
                & (state_q == S_IDLE)
                & ~flush;

  assign known = (op_type <= OP_INV);

`ifdef INVTLB_OP_CHECK_EN
  assign inv_bad = (op_type == OP_INV)
                 & (inv_op > 5'd6);
`else
  assign inv_bad = 1'b0;
`endif

  assign st_issue = (state_q == S_ISSUE);
  assign st_resp  = (state_q == S_RESP);
  assign st_done  = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (known && !inv_bad)
            state_d = S_ISSUE;
          else
            state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (op_q == OP_SRCH)
          state_d = S_RESP;
        else
          state_d = S_DONE;
      end
      S_RESP: begin
        state_d = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    ine_d   = ine_q;
    kill_d  = kill_q;
    rand_d  = rand_q;
    iop_d   = iop_q;
    iasid_d = iasid_q;
    ivpn_d  = ivpn_q;
    vaddr_d = vaddr_q;
    rdidx_d = rdidx_q;
    base_d  = base_q;
    idxw_d  = idxw_q;
    ehi_d   = ehi_q;
    elo0_d  = elo0_q;
    elo1_d  = elo1_q;
    asid_d  = asid_q;
    cnt_d   = wrap_inc(cnt_q);

    if (accept) begin
      op_d    = op_type;
      ine_d   = inv_bad;
      kill_d  = 1'b0;
      iop_d   = inv_op;
      iasid_d = inv_asid;
      ivpn_d  = inv_vpn;
      vaddr_d = {csr_tlbehi[31:13], 13'b0};
      rdidx_d = csr_tlbidx[IDX_W-1:0];
      base_d  = csr_tlbidx;
      if (op_type == OP_FILL) begin
        rand_d = cnt_q;
        // fill skips one extra slot
        cnt_d  = wrap_inc(wrap_inc(cnt_q));
      end
    end

    // flushed after the TLB update:
    // finish the op but do not refetch
    if (st_issue && flush)
      kill_d = 1'b1;

    if (st_issue && op_q == OP_RD) begin
      if (!rd_tlbidx[31]) begin
        ehi_d  = rd_tlbehi;
        elo0_d = rd_tlbelo0;
        elo1_d = rd_tlbelo1;
        asid_d = rd_asid;
        idxw_d = {1'b0, base_q[30],
                  rd_tlbidx[29:24],
                  base_q[23:0]};
      end else begin
        ehi_d  = '0;
        elo0_d = '0;
        elo1_d = '0;
        asid_d = '0;
        idxw_d = {1'b1, base_q[30],
                  6'b0, base_q[23:0]};
      end
    end

    if (st_resp) begin
      if (srch_found)
        idxw_d = {1'b0,
                  base_q[30:IDX_W],
                  srch_index};
      else
        idxw_d = {1'b1, base_q[30:0]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ine_q   <= 1'b0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      rand_q  <= '0;
      iop_q   <= '0;
      iasid_q <= '0;
      ivpn_q  <= '0;
      vaddr_q <= '0;
      rdidx_q <= '0;
      base_q  <= '0;
      idxw_q  <= '0;
      ehi_q   <= '0;
      elo0_q  <= '0;
      elo1_q  <= '0;
      asid_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ine_q   <= ine_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      rand_q  <= rand_d;
      iop_q   <= iop_d;
      iasid_q <= iasid_d;
      ivpn_q  <= ivpn_d;
      vaddr_q <= vaddr_d;
      rdidx_q <= rdidx_d;
      base_q  <= base_d;
      idxw_q  <= idxw_d;
      ehi_q   <= ehi_d;
      elo0_q  <= elo0_d;
      elo1_q  <= elo1_d;
      asid_q  <= asid_d;
    end
  end

  // a flushed search completes silently
  assign done_ok = st_done
                 & ~(flush & (op_q == OP_SRCH));

  assign ref_typ = (op_q == OP_RD)
                 | (op_q == OP_WR)
                 | (op_q == OP_FILL)
                 | (op_q == OP_INV);

  assign op_ready   = (state_q == S_IDLE);
  assign tlbwr_en   = st_issue & (op_q == OP_WR);
  assign tlbfill_en = st_issue & (op_q == OP_FILL);
  assign invtlb_en  = st_issue & (op_q == OP_INV);
  assign srch_fetch = st_issue & (op_q == OP_SRCH);

  assign rand_index   = rand_q;
  assign invtlb_op    = iop_q;
  assign invtlb_asid  = iasid_q;
  assign invtlb_vpn   = ivpn_q;
  assign srch_vaddr   = vaddr_q;
  assign rd_index     = rdidx_q;
  assign tlbidx_wdata = idxw_q;
  assign ehi_wdata    = ehi_q;
  assign elo0_wdata   = elo0_q;
  assign elo1_wdata   = elo1_q;
  assign asid_wdata   = asid_q;

  assign op_done   = done_ok;
  assign tlbidx_we = done_ok
                   & ((op_q == OP_SRCH)
                   |  (op_q == OP_RD));
  assign tlbrd_we  = done_ok & (op_q == OP_RD);
  assign refetch   = done_ok & ref_typ
                   & ~ine_q & ~kill_q & ~flush;
  assign op_ine    = done_ok & ine_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: randomized bench for tlb_op_ctrl
// Op-level latency model, per-cycle compare, literal pins.
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 32;
  localparam int IDX_W  = 5;
  localparam logic [31:0] IMASK = 32'(TLBNUM - 1);
`ifdef INVTLB_OP_CHECK_EN
  localparam int LIT_N = 9;
`else
  localparam int LIT_N = 8;
`endif

  logic clk, resetn, op_valid, op_ready, flush;
  logic [2:0] op_type;
  logic [4:0] inv_op, invtlb_op;
  logic [9:0] inv_asid, invtlb_asid, rd_asid, asid_wdata;
  logic [18:0] inv_vpn, invtlb_vpn;
  logic [31:0] csr_tlbehi, csr_tlbidx, srch_vaddr;
  logic tlbwr_en, tlbfill_en, invtlb_en, srch_fetch;
  logic srch_found, tlbidx_we, tlbrd_we;
  logic op_done, refetch, op_ine;
  logic [IDX_W-1:0] rand_index, srch_index, rd_index;
  logic [31:0] rd_tlbehi, rd_tlbelo0, rd_tlbelo1, rd_tlbidx;
  logic [31:0] tlbidx_wdata, ehi_wdata;
  logic [31:0] elo0_wdata, elo1_wdata;

  logic [31:0] t_ehi [TLBNUM];
  logic [31:0] t_elo0 [TLBNUM];
  logic [31:0] t_elo1 [TLBNUM];
  logic [31:0] t_idx [TLBNUM];
  logic [9:0]  t_asid [TLBNUM];

  assign rd_tlbehi  = t_ehi[rd_index];
  assign rd_tlbelo0 = t_elo0[rd_index];
  assign rd_tlbelo1 = t_elo1[rd_index];
  assign rd_tlbidx  = t_idx[rd_index];
  assign rd_asid    = t_asid[rd_index];

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .inv_op(inv_op),
    .inv_asid(inv_asid), .inv_vpn(inv_vpn),
    .flush(flush),
    .csr_tlbehi(csr_tlbehi), .csr_tlbidx(csr_tlbidx),
    .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en),
    .rand_index(rand_index), .invtlb_en(invtlb_en),
    .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vpn(invtlb_vpn),
    .srch_fetch(srch_fetch), .srch_vaddr(srch_vaddr),
    .srch_found(srch_found), .srch_index(srch_index),
    .rd_index(rd_index),
    .rd_tlbehi(rd_tlbehi), .rd_tlbelo0(rd_tlbelo0),
    .rd_tlbelo1(rd_tlbelo1), .rd_tlbidx(rd_tlbidx),
    .rd_asid(rd_asid),
    .tlbidx_we(tlbidx_we), .tlbidx_wdata(tlbidx_wdata),
    .tlbrd_we(tlbrd_we), .ehi_wdata(ehi_wdata),
    .elo0_wdata(elo0_wdata), .elo1_wdata(elo1_wdata),
    .asid_wdata(asid_wdata),
    .op_done(op_done), .refetch(refetch), .op_ine(op_ine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lit_hits = 0;
  int d_tag = 0;
  bit fin_req = 1'b0;
  bit tmo = 1'b0;

  // model: current op and its age in cycles since accept
  int m_age = 0, m_op = 0, m_lat = 0, m_tag = 0, m_cnt = 0;
  bit m_ine = 1'b0, m_kill = 1'b0, seen7 = 1'b0;
  bit m_found = 1'b0;
  logic [IDX_W-1:0] m_sidx = '0, m_rand = '0;
  logic [31:0] m_base = '0, m_key = '0;
  logic [4:0]  m_iop = '0;
  logic [9:0]  m_iasid = '0;
  logic [18:0] m_ivpn = '0;
  logic [31:0] r_ehi = '0, r_elo0 = '0, r_elo1 = '0;
  logic [31:0] r_idx = '0;
  logic [9:0]  r_asid = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  bit busy, dcyc, abort, e_done, e_ref;
  bit e_wr, e_fill, e_inv, e_fetch, e_idx, e_rdwe, acc;
  logic [31:0] e_w;

  initial begin
    forever begin
      @(negedge clk);
      if (fin_req) begin
        chk("timeout", 32'(tmo), 32'd0);
        chk("lit_hits", 32'(lit_hits), 32'(LIT_N));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!resetn) begin
        if (m_tag == 8 && m_age == 1) begin
          chk("rst_issue_wr", 32'(tlbwr_en), 32'd0);
          lit_hits++;
        end
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_pulses", 32'({tlbwr_en, tlbfill_en,
            invtlb_en, srch_fetch, tlbidx_we, tlbrd_we,
            op_done, refetch, op_ine}), 32'd0);
        chk("rst_rand", 32'(rand_index), 32'd0);
        chk("rst_idxw", tlbidx_wdata, 32'd0);
        chk("rst_vaddr", srch_vaddr, 32'd0);
        m_age = 0; m_cnt = 0; m_tag = 0; seen7 = 1'b0;
        m_rand = '0; m_base = '0;
      end else begin
        busy    = (m_age > 0);
        dcyc    = busy && (m_age == m_lat);
        abort   = dcyc && m_op == 0 && flush;
        e_done  = dcyc && !abort;
        e_wr    = m_age == 1 && m_lat > 1 && m_op == 2;
        e_fill  = m_age == 1 && m_lat > 1 && m_op == 3;
        e_inv   = m_age == 1 && m_lat > 1 && m_op == 4;
        e_fetch = m_age == 1 && m_op == 0;
        e_idx   = e_done && (m_op == 0 || m_op == 1);
        e_rdwe  = e_done && m_op == 1;
        e_ref   = e_done && m_op >= 1 && m_op <= 4
                  && !m_ine && !m_kill && !flush;

        chk("op_ready", 32'(op_ready), 32'(!busy));
        chk("tlbwr_en", 32'(tlbwr_en), 32'(e_wr));
        chk("tlbfill_en", 32'(tlbfill_en), 32'(e_fill));
        chk("invtlb_en", 32'(invtlb_en), 32'(e_inv));
        chk("srch_fetch", 32'(srch_fetch), 32'(e_fetch));
        chk("op_done", 32'(op_done), 32'(e_done));
        chk("tlbidx_we", 32'(tlbidx_we), 32'(e_idx));
        chk("tlbrd_we", 32'(tlbrd_we), 32'(e_rdwe));
        chk("refetch", 32'(refetch), 32'(e_ref));
        chk("op_ine", 32'(op_ine), 32'(e_done && m_ine));

        if (e_fill)
          chk("rand_index", 32'(rand_index), 32'(m_rand));
        if (e_inv) begin
          chk("inv_op", 32'(invtlb_op), 32'(m_iop));
          chk("inv_asid", 32'(invtlb_asid), 32'(m_iasid));
          chk("inv_vpn", 32'(invtlb_vpn), 32'(m_ivpn));
        end
        if (e_fetch)
          chk("srch_vaddr", srch_vaddr,
              m_key & 32'hFFFF_E000);
        if (m_age == 1 && m_op == 1)
          chk("rd_index", 32'(rd_index), m_base & IMASK);
        if (e_idx) begin
          if (m_op == 0)
            e_w = m_found
              ? ((m_base & ~32'h8000_0000 & ~IMASK)
                 | 32'(m_sidx))
              : (m_base | 32'h8000_0000);
          else
            e_w = r_idx[31]
              ? ((m_base & ~32'h3F00_0000) | 32'h8000_0000)
              : ((m_base & ~32'hBF00_0000)
                 | (r_idx & 32'h3F00_0000));
          chk("tlbidx_wdata", tlbidx_wdata, e_w);
        end
        if (e_rdwe) begin
          chk("ehi_wdata", ehi_wdata, r_idx[31] ? 0 : r_ehi);
          chk("elo0_wdata", elo0_wdata,
              r_idx[31] ? 0 : r_elo0);
          chk("elo1_wdata", elo1_wdata,
              r_idx[31] ? 0 : r_elo1);
          chk("asid_wdata", 32'(asid_wdata),
              r_idx[31] ? 0 : 32'(r_asid));
        end

        if (seen7) begin
          chk("L6_ready", 32'(op_ready), 32'd1);
          chk("L6_no_we", 32'(tlbidx_we), 32'd0);
          lit_hits++;
          seen7 = 1'b0;
        end
        if (m_tag == 1 && m_age == 1) begin
          chk("L1_rand", 32'(rand_index), 32'd7);
          chk("L1_fill", 32'(tlbfill_en), 32'd1);
          lit_hits++;
        end
        if (m_tag == 1 && m_age == 2) begin
          chk("L1_done", 32'(op_done), 32'd1);
          chk("L1_ref", 32'(refetch), 32'd1);
          lit_hits++;
        end
        if (m_tag == 2 && m_age == 3) begin
          chk("L2_we", 32'(tlbidx_we), 32'd1);
          chk("L2_wd", tlbidx_wdata, 32'h0C00_0005);
          lit_hits++;
        end
        if (m_tag == 3 && m_age == 3) begin
          chk("L3_wd", tlbidx_wdata, 32'h8C00_0003);
          chk("L3_ref", 32'(refetch), 32'd0);
          lit_hits++;
        end
        if (m_tag == 4 && m_age == 2) begin
          chk("L4_ehi", ehi_wdata, 32'd0);
          chk("L4_elo0", elo0_wdata, 32'd0);
          chk("L4_elo1", elo1_wdata, 32'd0);
          chk("L4_asid", 32'(asid_wdata), 32'd0);
          chk("L4_idx", tlbidx_wdata, 32'h8000_0004);
          chk("L4_we", 32'(tlbrd_we), 32'd1);
          lit_hits++;
        end
        if (m_tag == 5 && m_age == 1) begin
          chk("L5_en", 32'(invtlb_en), 32'd1);
          chk("L5_op", 32'(invtlb_op), 32'd2);
          lit_hits++;
        end
        if (m_tag == 6 && m_age == 1) begin
          chk("L5b_en", 32'(invtlb_en), 32'd0);
          chk("L5b_ine", 32'(op_ine), 32'd1);
          lit_hits++;
        end

        acc = !busy && op_valid && !flush;
        if (busy) begin
          if (m_age == 1 && flush) m_kill = 1'b1;
          if (m_age == 1 && m_op == 1) begin
            r_ehi  = t_ehi[m_base & IMASK];
            r_elo0 = t_elo0[m_base & IMASK];
            r_elo1 = t_elo1[m_base & IMASK];
            r_idx  = t_idx[m_base & IMASK];
            r_asid = t_asid[m_base & IMASK];
          end
          if (m_age == 2 && m_op == 0) begin
            m_found = srch_found;
            m_sidx  = srch_index;
          end
          if (dcyc || (m_age == 2 && m_op == 0 && flush)) begin
            if (m_tag == 7 && m_age == 2) seen7 = 1'b1;
            m_age = 0;
            m_tag = 0;
          end else begin
            m_age++;
          end
        end else if (acc) begin
          m_op    = int'(op_type);
          m_tag   = d_tag;
          m_base  = csr_tlbidx;
          m_key   = csr_tlbehi;
          m_iop   = inv_op;
          m_iasid = inv_asid;
          m_ivpn  = inv_vpn;
          m_kill  = 1'b0;
`ifdef INVTLB_OP_CHECK_EN
          m_ine = (m_op == 4) && (inv_op > 5'd6);
`else
          m_ine = 1'b0;
`endif
          if (m_op > 4 || m_ine) m_lat = 1;
          else if (m_op == 0)    m_lat = 3;
          else                   m_lat = 2;
          if (m_op == 3) m_rand = m_cnt[IDX_W-1:0];
          m_age = 1;
        end
        m_cnt = (m_cnt + 1 + ((acc && op_type == 3'd3) ? 1 : 0))
                % TLBNUM;
      end
    end
  end

  task automatic run_op(input int ty, input int tag,
                        input logic [31:0] idx,
                        input logic [4:0] iop);
    bit fin;
    csr_tlbidx = idx;
    csr_tlbehi = $urandom;
    inv_op     = iop;
    inv_asid   = 10'($urandom);
    inv_vpn    = 19'($urandom);
    op_type    = 3'(ty);
    op_valid   = 1'b1;
    flush      = 1'b0;
    d_tag      = tag;
    @(posedge clk); #1;
    op_valid = 1'b0;
    d_tag    = 0;
    fin      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_age == 0) begin
        fin = 1'b1;
        break;
      end
      flush  = (tag == 7 && m_age == 2);
      resetn = !(tag == 8 && m_age == 1);
      srch_found = (tag == 2) ? 1'b1 :
                   (tag == 3) ? 1'b0 :
                   1'($urandom_range(0, 1));
      srch_index = (tag == 2) ? IDX_W'(5) :
                   IDX_W'($urandom);
      @(posedge clk); #1;
      flush  = 1'b0;
      resetn = 1'b1;
    end
    if (!fin) tmo = 1'b1;
  endtask

  initial begin
    resetn = 1'b1; op_valid = 1'b0; flush = 1'b0;
    op_type = '0; inv_op = '0; inv_asid = '0; inv_vpn = '0;
    csr_tlbehi = '0; csr_tlbidx = '0;
    srch_found = 1'b0; srch_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      t_ehi[i]  = $urandom;
      t_elo0[i] = $urandom;
      t_elo1[i] = $urandom;
      t_idx[i]  = $urandom;
      t_asid[i] = 10'($urandom);
    end
    t_idx[4] = 32'h8000_0000;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    begin
      bit hit7;
      hit7 = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (m_age == 0 && m_cnt == 7) begin
          hit7 = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!hit7) tmo = 1'b1;
    end
    run_op(3, 1, 32'h0000_0000, 5'd0);
    run_op(0, 2, 32'h8C00_0003, 5'd0);
    run_op(0, 3, 32'h0C00_0003, 5'd0);
    run_op(1, 4, 32'h0000_0004, 5'd0);
    run_op(4, 5, 32'h0000_0000, 5'd2);
`ifdef INVTLB_OP_CHECK_EN
    run_op(4, 6, 32'h0000_0000, 5'd9);
`endif
    run_op(0, 7, 32'h0000_0011, 5'd0);
    run_op(2, 8, 32'h0000_0000, 5'd0);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      resetn     = 1'b1;
      flush      = 1'b0;
      srch_found = 1'($urandom_range(0, 1));
      srch_index = IDX_W'($urandom);
      if (m_age == 0) begin
        csr_tlbidx = $urandom;
        csr_tlbehi = $urandom;
        inv_op     = 5'($urandom);
        inv_asid   = 10'($urandom);
        inv_vpn    = 19'($urandom);
        op_type    = 3'($urandom_range(0, 7));
        op_valid   = ($urandom_range(0, 9) < 7);
        flush      = op_valid && ($urandom_range(0, 9) == 0);
      end else begin
        op_valid = 1'($urandom_range(0, 1));
        op_type  = 3'($urandom);
        if (m_age == 1 && m_lat > 1 &&
            $urandom_range(0, 6) == 0)
          flush = 1'b1;
        if (m_op == 0 && m_age >= 2 &&
            $urandom_range(0, 6) == 0)
          flush = 1'b1;
        if ($urandom_range(0, 99) == 0)
          resetn = 1'b0;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0; resetn = 1'b1;
    begin
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (m_age == 0) begin
          idle = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!idle) tmo = 1'b1;
    end
    fin_req = 1'b1;
    #200;
    $display("FAIL finish_hang");
    $fatal(1);
  end

endmodule
